// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage (main + skid) with flush, freeze/stall counting
// and bubble-safe control output.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 96,
   parameter int unsigned CTRL_W = 9,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_valid_q, main_valid_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CNT_W-1:0]  stall_q,      stall_d;
   logic              accept, drain;

   // in_ready depends only on the skid flop and freeze, never on out_ready
   assign in_ready  = ~skid_valid_q & ~freeze;
   assign accept    = in_valid & in_ready & ~flush;
   assign drain     = main_valid_q & out_ready & ~freeze & ~flush;

   assign out_valid = main_valid_q;
   assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
   assign out_data  = main_data_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign stall_cnt = stall_q;

   always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      stall_d      = stall_q;

      if (freeze && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain && skid_valid_q) begin
         // skid full implies in_ready=0, so no accept can coincide here
         main_ctrl_d  = skid_ctrl_q;
         main_data_d  = skid_data_q;
         skid_valid_d = 1'b0;
      end else if (drain) begin
         main_valid_d = accept;
         if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
         end
      end else if (accept) begin
         if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
         end else begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_ctrl_q  <= '0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         stall_q      <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_ctrl_q  <= main_ctrl_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         stall_q      <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: expected entries queued on accept,
// compared at the head and popped on drain.
module tb_pipe_stage_reg;

   typedef struct {
      logic [8:0]  c;
      logic [95:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, flush, freeze, in_valid, out_ready;
   logic [8:0]  in_ctrl;
   logic [95:0] in_data;

   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [8:0]  out_ctrl, out_ctrl2;
   logic [95:0] out_data, out_data2;
   logic [1:0]  occupancy, occupancy2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   ent_t        sb[$];
   logic [95:0] last_data;
   logic [15:0] stall_exp;
   logic [1:0]  stall2_exp;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(96), .CTRL_W(9), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.DATA_W(96), .CTRL_W(9), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
      .occupancy(occupancy2), .stall_cnt(stall_cnt2)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [8:0]  ec;
      logic [95:0] ed;
      ec = '0;
      ed = last_data;
      if (sb.size() > 0) begin
         ec = sb[0].c;
         ed = sb[0].d;
      end
      chk("out_valid", 128'(out_valid), 128'(sb.size() > 0));
      chk("occupancy", 128'(occupancy), 128'(sb.size()));
      chk("in_ready",  128'(in_ready),  128'((sb.size() < 2) && !freeze));
      chk("out_ctrl",  128'(out_ctrl),  128'(ec));
      chk("out_data",  128'(out_data),  128'(ed));
      chk("stall_cnt", 128'(stall_cnt), 128'(stall_exp));
      chk("stall_cnt_w2", 128'(stall_cnt2), 128'(stall2_exp));
   endtask

   // One clock: drive at negedge, check before the rising edge, advance model
   task automatic cyc(input logic v, input logic [8:0] c, input logic [95:0] d,
                      input logic ordy, input logic fl, input logic fz);
      logic acc, drn;
      ent_t e;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      freeze    = fz;
      #1;
      check_all();
      acc = v && (sb.size() < 2) && !fz && !fl;
      drn = (sb.size() > 0) && ordy && !fz && !fl;
      @(posedge clk);
      if (fz) begin
         if (stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
         if (stall2_exp != 2'd3)    stall2_exp = stall2_exp + 2'd1;
      end
      if (sb.size() > 0) last_data = sb[0].d;
      if (fl) begin
         sb.delete();
      end else begin
         if (drn) void'(sb.pop_front());
         if (acc) begin
            e.c = c;
            e.d = d;
            sb.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      sb.delete();
      last_data  = '0;
      stall_exp  = '0;
      stall2_exp = '0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;
      model_reset();
      @(negedge clk);
      #1;
      check_all();
      freeze = 1'b1;
      #1;
      chk("rst_in_ready_freeze", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("rst_stall_hold", 128'(stall_cnt), 128'(0));
      freeze = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // single entry, one-cycle latency, then drained
      cyc(1, 9'h1A5, 96'h0A, 1, 0, 0);
      chk("first_latency_data", 128'(out_data), 128'(96'h0A));
      cyc(0, 9'h000, 96'h00, 1, 0, 0);
      cyc(0, 9'h000, 96'h00, 1, 0, 0);

      // A, B fill main+skid, C held off, then drain in order
      cyc(1, 9'h101, 96'hA, 0, 0, 0);
      cyc(1, 9'h102, 96'hB, 0, 0, 0);
      cyc(1, 9'h103, 96'hC, 0, 0, 0);
      chk("full_occ", 128'(occupancy), 128'(2));
      cyc(1, 9'h103, 96'hC, 0, 0, 0);
      cyc(1, 9'h103, 96'hC, 1, 0, 0);
      cyc(1, 9'h103, 96'hC, 1, 0, 0);
      chk("c_in_main", 128'(out_data), 128'(96'hC));
      cyc(0, 9'h000, 96'h0, 1, 0, 0);
      cyc(0, 9'h000, 96'h0, 1, 0, 0);

      // occupancy 1 with simultaneous accept+drain
      cyc(1, 9'h111, 96'h11, 1, 0, 0);
      cyc(1, 9'h112, 96'h12, 1, 0, 0);
      cyc(1, 9'h113, 96'h13, 1, 0, 0);
      cyc(0, 9'h000, 96'h0, 1, 0, 0);

      // flush at occupancy 2 drops held entries and incoming D
      cyc(1, 9'h1E1, 96'hE, 0, 0, 0);
      cyc(1, 9'h1F1, 96'hF, 0, 0, 0);
      cyc(1, 9'h1D1, 96'hD, 0, 1, 0);
      cyc(0, 9'h000, 96'h0, 1, 0, 0);
      cyc(0, 9'h000, 96'h0, 1, 0, 0);

      // freeze 5 cycles with one held entry and out_ready=1
      cyc(1, 9'h1C7, 96'h77, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 9'h1C8, 96'h78, 1, 0, 1);
      chk("stall_five", 128'(stall_cnt), 128'(5));
      cyc(0, 9'h000, 96'h0, 1, 0, 0);
      cyc(0, 9'h000, 96'h0, 1, 0, 0);

      // further freeze: narrow counter stays saturated at 3
      for (int i = 0; i < 6; i++) cyc(0, 9'h000, 96'h0, 1, 0, 1);
      chk("sat_w2", 128'(stall_cnt2), 128'(3));
      // flush coincident with freeze: flush wins, counter still advances
      cyc(1, 9'h1A1, 96'h21, 0, 0, 0);
      cyc(1, 9'h1A2, 96'h22, 0, 1, 1);
      cyc(0, 9'h000, 96'h0, 1, 0, 0);

      // asynchronous reset between edges at occupancy 2
      cyc(1, 9'h1B1, 96'h31, 0, 0, 0);
      cyc(1, 9'h1B2, 96'h32, 0, 0, 0);
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valid", 128'(out_valid), 128'(0));
      chk("arst_occ",   128'(occupancy), 128'(0));
      chk("arst_ctrl",  128'(out_ctrl),  128'(0));
      chk("arst_data",  128'(out_data),  128'(0));
      chk("arst_ready", 128'(in_ready),  128'(1));
      chk("arst_stall", 128'(stall_cnt), 128'(0));
      #1;
      rst = 1'b0;
      model_reset();
      cyc(1, 9'h1B3, 96'h33, 0, 0, 0);
      chk("post_rst_occ", 128'(occupancy), 128'(1));
      cyc(0, 9'h000, 96'h0, 1, 0, 0);

      // random traffic for FIFO ordering
      for (int i = 0; i < 80; i++) begin
         cyc(1'($urandom_range(0, 1)), 9'($urandom), {$urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0));
      end
      for (int i = 0; i < 3; i++) cyc(0, 9'h000, 96'h0, 1, 0, 0);
      check_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
